// File: rtl/ram_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : ram_word_loader
// Purpose  : Assembles pairs of received UART bytes into 16-bit words and
//            writes them to consecutive SRAM addresses using a SETUP / WRITE /
//            HOLD strobe sequence with registered bus outputs.
// Revision : 1.0  initial release
// ============================================================================
module ram_word_loader #(
  parameter logic [15:0] WORDS         = 16'd4,
  parameter int unsigned WE_LOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic [15:0] ram1addr,
  output logic [15:0] ram1data,
  output logic        data_oe,
  output logic        ram1_WE_L,
  output logic        ram1_OE_L,
  output logic        ram1_CE,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_SETUP = 3'd3,
    S_WRITE = 3'd4,
    S_HOLD  = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Terminal value of the WE_L low-phase counter.
  localparam logic [3:0] c_WE_LAST = 4'(WE_LOW_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] word_q, word_d;
  logic [15:0] wc_q, wc_d;
  logic [3:0]  we_cnt_q, we_cnt_d;
  logic        armed_q, armed_d;

  logic        rx_ack_q, rx_ack_d;
  logic [15:0] ram1addr_q, ram1addr_d;
  logic [15:0] ram1data_q, ram1data_d;
  logic        data_oe_q, data_oe_d;
  logic        we_l_q, we_l_d;
  logic        ce_q, ce_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;

  logic        accept;
  logic [15:0] wc_inc;

  // Next-state logic plus the next value of every registered output, which is
  // derived from the state being entered so outputs line up with the state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    wc_d     = wc_q;
    we_cnt_d = we_cnt_q;
    // A byte is only accepted once rx_valid has been seen low since the last
    // acceptance, so a byte still held high after its ack is never re-read.
    armed_d  = armed_q | ~rx_valid;
    accept   = 1'b0;
    wc_inc   = wc_q + 16'd1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = base_addr;
          wc_d    = 16'd0;
          armed_d = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (rx_valid && armed_q) begin
          word_d[7:0] = rx_data;
          accept      = 1'b1;
          armed_d     = 1'b0;
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (rx_valid && armed_q) begin
          word_d[15:8] = rx_data;
          accept       = 1'b1;
          armed_d      = 1'b0;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        we_cnt_d = 4'd0;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (we_cnt_q == c_WE_LAST) begin
          state_d = S_HOLD;
        end else begin
          we_cnt_d = we_cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d  = addr_q + 16'd1;
        wc_d    = wc_inc;
        state_d = (wc_inc == WORDS) ? S_DONE : S_LO;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rx_ack_d   = accept;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    ce_d       = ~busy_d;
    done_d     = (state_d == S_DONE);
    data_oe_d  = (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);
    we_l_d     = (state_d != S_WRITE);
    ram1addr_d = ram1addr_q;
    ram1data_d = ram1data_q;
    result_d   = result_q;

    // Address and data are loaded on entry to SETUP and then held through
    // WRITE and HOLD, so they are stable a full cycle before WE_L falls.
    if (state_d == S_SETUP) begin
      ram1addr_d = addr_q;
      ram1data_d = word_d;
    end

    if (state_q == S_NEXT) begin
      result_d = {wc_inc[7:0], word_q[7:0]};
    end
  end

  // State, datapath and output registers; reset forces the bus idle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'd0;
      word_q     <= 16'd0;
      wc_q       <= 16'd0;
      we_cnt_q   <= 4'd0;
      armed_q    <= 1'b1;
      rx_ack_q   <= 1'b0;
      ram1addr_q <= 16'd0;
      ram1data_q <= 16'd0;
      data_oe_q  <= 1'b0;
      we_l_q     <= 1'b1;
      ce_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wc_q       <= wc_d;
      we_cnt_q   <= we_cnt_d;
      armed_q    <= armed_d;
      rx_ack_q   <= rx_ack_d;
      ram1addr_q <= ram1addr_d;
      ram1data_q <= ram1data_d;
      data_oe_q  <= data_oe_d;
      we_l_q     <= we_l_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign rx_ack    = rx_ack_q;
  assign ram1addr  = ram1addr_q;
  assign ram1data  = ram1data_q;
  assign data_oe   = data_oe_q;
  assign ram1_WE_L = we_l_q;
  assign ram1_OE_L = 1'b1;
  assign ram1_CE   = ce_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_word_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ram_word_loader
// Purpose  : Scoreboard bench for ram_word_loader: sessions push expected SRAM
//            writes, a bus monitor pops and checks each completed strobe.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_word_loader;

  localparam int          NWORDS = 4;
  localparam logic [15:0] WORDS  = 16'(NWORDS);
  localparam int          WE_LOW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ack;
  logic [15:0] ram1addr;
  logic [15:0] ram1data;
  logic        data_oe;
  logic        ram1_WE_L;
  logic        ram1_OE_L;
  logic        ram1_CE;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  sb [2*NWORDS];

  always #5 clk = ~clk;

  ram_word_loader #(
    .WORDS         (WORDS),
    .WE_LOW_CYCLES (WE_LOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ack    (rx_ack),
    .ram1addr  (ram1addr),
    .ram1data  (ram1data),
    .data_oe   (data_oe),
    .ram1_WE_L (ram1_WE_L),
    .ram1_OE_L (ram1_OE_L),
    .ram1_CE   (ram1_CE),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus monitor: one sample per cycle, away from the rising edge.
  logic        p_we = 1'b1;
  logic        p_oe = 1'b0;
  logic [15:0] p_addr = 16'd0;
  logic [15:0] p_data = 16'd0;
  int          low_cnt = 0;
  logic [31:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      p_we    = 1'b1;
      p_oe    = 1'b0;
      low_cnt = 0;
    end else begin
      if (ram1_WE_L !== 1'b1) begin
        chk(data_oe === 1'b1, "oe_during_we", 32'(data_oe), 32'd1);
        if (p_we) begin
          chk(p_oe === 1'b1, "oe_before_we", 32'(p_oe), 32'd1);
          chk({p_addr, p_data} === {ram1addr, ram1data}, "setup_before_we",
              {p_addr, p_data}, {ram1addr, ram1data});
          low_cnt = 1;
        end else begin
          low_cnt++;
          chk({ram1addr, ram1data} === {p_addr, p_data}, "stable_during_we",
              {ram1addr, ram1data}, {p_addr, p_data});
        end
      end else if (!p_we) begin
        chk(low_cnt == WE_LOW, "we_low_width", 32'(low_cnt), 32'(WE_LOW));
        chk(data_oe === 1'b1, "oe_after_we", 32'(data_oe), 32'd1);
        chk({ram1addr, ram1data} === {p_addr, p_data}, "hold_after_we",
            {ram1addr, ram1data}, {p_addr, p_data});
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", {ram1addr, ram1data}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({ram1addr, ram1data} === e, "write_addr_data", {ram1addr, ram1data}, e);
        end
      end
      chk(ram1_OE_L === 1'b1, "oe_l_const", 32'(ram1_OE_L), 32'd1);
      p_we   = ram1_WE_L;
      p_oe   = data_oe;
      p_addr = ram1addr;
      p_data = ram1data;
    end
  end

  task automatic check_reset_outputs(input string name);
    chk({rx_ack, data_oe, ram1_WE_L, ram1_OE_L, ram1_CE, busy, done} === 7'b0011100,
        name, {25'd0, rx_ack, data_oe, ram1_WE_L, ram1_OE_L, ram1_CE, busy, done}, 32'h1C);
    chk({ram1addr, ram1data} === 32'd0, {name, "_bus"}, {ram1addr, ram1data}, 32'd0);
    chk(result === 16'd0, {name, "_result"}, 32'(result), 32'd0);
  endtask

  // Upstream byte source; hold5 keeps rx_valid high at least five cycles.
  task automatic send_byte(input logic [7:0] b, input bit hold5);
    int cyc = 0;
    int acks = 0;
    bit dropped = 1'b0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!dropped && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rx_ack === 1'b1) acks++;
      if (acks > 0 && (!hold5 || cyc >= 5)) begin
        rx_valid = 1'b0;
        dropped  = 1'b1;
      end
    end
    if (!dropped) begin
      rx_valid = 1'b0;
      chk(1'b0, "ack_timeout", 32'(cyc), 32'd200);
    end
    repeat (1 + $urandom_range(0, 2)) begin
      @(negedge clk);
      if (rx_ack === 1'b1) acks++;
    end
    chk(acks == 1, "acks_per_byte", 32'(acks), 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2*NWORDS; i++) sb[i] = 8'($urandom);
  endtask

  task automatic run_session(input logic [15:0] base, input bit hold5, input bit start_in_hi);
    int n = 0;
    logic [15:0] wa;
    @(negedge clk);
    base_addr = base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 16'($urandom);
    chk({busy, done, ram1_CE} === 3'b100, "session_start", {29'd0, busy, done, ram1_CE}, 32'h4);
    for (int w = 0; w < NWORDS; w++) begin
      wa = base + 16'(w);
      exp_q.push_back({wa, sb[2*w+1], sb[2*w]});
      send_byte(sb[2*w], hold5);
      if (start_in_hi && w == 0) begin
        start     = 1'b1;
        base_addr = 16'h5555;
        @(negedge clk);
        start     = 1'b0;
      end
      send_byte(sb[2*w+1], hold5);
    end
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(done === 1'b1, "done_reached", 32'(done), 32'd1);
    chk(result === {WORDS[7:0], sb[2*NWORDS-2]}, "result", 32'(result),
        32'({WORDS[7:0], sb[2*NWORDS-2]}));
    chk({busy, ram1_CE, data_oe, ram1_WE_L} === 4'b0101, "done_outputs",
        {28'd0, busy, ram1_CE, data_oe, ram1_WE_L}, 32'h5);
    chk(exp_q.size() == 0, "writes_complete", 32'(exp_q.size()), 32'd0);
  endtask

  // Session interrupted by reset while word 1 is being strobed.
  task automatic reset_mid_write();
    int n = 0;
    logic [15:0] wa;
    fill_random();
    @(negedge clk);
    base_addr = 16'h0300;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wa = 16'h0300 + 16'(w);
      exp_q.push_back({wa, sb[2*w+1], sb[2*w]});
      send_byte(sb[2*w], 1'b0);
      if (w == 0) send_byte(sb[2*w+1], 1'b0);
    end
    @(negedge clk);
    rx_data  = sb[3];
    rx_valid = 1'b1;
    while (ram1_WE_L !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
      if (rx_ack === 1'b1) rx_valid = 1'b0;
    end
    chk(ram1_WE_L === 1'b0, "reached_write_word1", 32'(ram1_WE_L), 32'd0);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk(ram1_WE_L === 1'b1, "we_async_reset", 32'(ram1_WE_L), 32'd1);
    check_reset_outputs("mid_write_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk({busy, done, ram1_WE_L} === 3'b001, "idle_after_reset",
        {29'd0, busy, done, ram1_WE_L}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_outputs("por_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk({busy, done, ram1_WE_L, ram1_CE} === 4'b0011, "idle_before_start",
        {28'd0, busy, done, ram1_WE_L, ram1_CE}, 32'h3);

    sb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_session(16'h0100, 1'b0, 1'b0);

    fill_random();
    run_session(16'hFFFE, 1'b1, 1'b0);

    fill_random();
    run_session(16'(($urandom)), 1'b0, 1'b1);

    reset_mid_write();

    fill_random();
    run_session(16'h0200, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_session(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_word_loader.md
RAM_WORD_LOADER -- requirements
Module: ram_word_loader

Interface
REQ-001 Parameter WORDS, 16'd4, number of 16-bit words written per load session (legal 1..65535).
REQ-002 Parameter WE_LOW_CYCLES, 2, clk cycles ram1_WE_L held low per word write (legal 1..15).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; sampled in IDLE/DONE to begin a session.
REQ-006 base_addr  input  16  first SRAM word address; captured on session start.
REQ-007 rx_valid  input  1  upstream UART byte available; held until acked.
REQ-008 rx_data  input  8  received byte; stable while rx_valid=1.
REQ-009 rx_ack  output  1  one-cycle pulse: byte consumed.
REQ-010 ram1addr  output  16  SRAM address.
REQ-011 ram1data  output  16  SRAM write data.
REQ-012 data_oe  output  1  1 = loader drives ram1 data bus; 0 = bus tri-stated by top level.
REQ-013 ram1_WE_L  output  1  SRAM write enable, active-low.
REQ-014 ram1_OE_L  output  1  SRAM output enable, active-low; constant 1 in this block.
REQ-015 ram1_CE  output  1  SRAM chip enable, active-low; 0 while busy, 1 otherwise.
REQ-016 busy  output  1  session in progress.
REQ-017 done  output  1  high in DONE state.
REQ-018 result  output  16  {word_count[7:0], last written word low byte[7:0]} for LED display.

Function
REQ-019 FSM states: IDLE, LO, HI, SETUP, WRITE, HOLD, NEXT, DONE; all outputs registered.
REQ-020 IDLE or DONE, start=1: capture base_addr into addr, clear word_count, go to LO; else stay.
REQ-021 LO, rx_valid=1: latch rx_data into word[7:0], rx_ack=1 next cycle, go to HI.
REQ-022 HI, rx_valid=1: latch rx_data into word[15:8], rx_ack=1 next cycle, go to SETUP.
REQ-023 rx_valid in any state other than LO/HI: not acked, no data latched (back-pressure).
REQ-024 HI entered with rx_valid still high from the LO byte: that byte is not re-consumed; HI accepts only after rx_valid has been low at least one cycle.
REQ-025 SETUP (1 cycle): ram1addr=addr, ram1data=word, data_oe=1, ram1_WE_L=1.
REQ-026 WRITE (WE_LOW_CYCLES cycles): ram1_WE_L=0, addr/data/data_oe unchanged.
REQ-027 HOLD (1 cycle): ram1_WE_L=1, addr/data still driven, data_oe=1.
REQ-028 NEXT (1 cycle): data_oe=0, addr+=1 modulo 2^16, word_count+=1; go to DONE if new word_count==WORDS, else LO.
REQ-029 Address wrap: 16'hFFFF increments to 16'h0000, no flag, session continues.
REQ-030 DONE: done=1, busy=0, ram1_CE=1, data_oe=0; start=1 restarts per REQ-020.
REQ-031 start changes while busy: ignored.
REQ-032 busy=1 in LO, HI, SETUP, WRITE, HOLD, NEXT.
REQ-033 Write latency per word: 3+WE_LOW_CYCLES cycles from HI acceptance to return to LO.
REQ-034 data_oe=1 and ram1_WE_L=0 never without stable addr/data set one cycle earlier (SETUP precedes WRITE).

Reset
REQ-035 rst=0 asynchronously: state IDLE, ram1_WE_L=1, ram1_OE_L=1, ram1_CE=1, data_oe=0, rx_ack=0, busy=0, done=0, ram1addr=0, ram1data=0, result=0, word_count=0.
REQ-036 Reset mid-WRITE: ram1_WE_L returns high in same cycle (no clock needed); partial word discarded.
REQ-037 Leaving reset: first action only on next start; no SRAM strobe before.

Verification
REQ-038 WORDS=4, base_addr=16'h0100, start, bytes 11 22 33 44 55 66 77 88 -> writes 0100:2211, 0101:4433, 0102:6655, 0103:8877; done=1; result=16'h0477.
REQ-039 base_addr=16'hFFFF, WORDS=2, bytes AA BB CC DD -> writes FFFF:BBAA, 0000:DDCC.
REQ-040 rx_valid held high 5 cycles per byte -> exactly one rx_ack per byte, no duplicate latch.
REQ-041 Each write: WE_L low exactly WE_LOW_CYCLES cycles; addr/data stable and data_oe=1 from one cycle before falling to one cycle after rising WE_L edge.
REQ-042 rst=0 asserted during WRITE of word 1 -> WE_L=1 immediately, all outputs at REQ-035 values; new start with base 16'h0200 writes from 0200.
REQ-043 start pulsed during HI -> no restart; session completes at original addresses.
